// File: rtl/ifu_fq_if.sv
// ifu_fq_if: generic valid/ready handshake carrying a packed payload.
// The master drives vld/pkt, the slave drives rdy.
`ifndef RV_PC_SIZE
`define RV_PC_SIZE 32
`endif
`ifndef RV_IR_SIZE
`define RV_IR_SIZE 32
`endif

interface ifu_fq_if #(
    parameter int W = 32
);
    logic         vld;
    logic         rdy;
    logic [W-1:0] pkt;

    modport mst (
        output vld,
        output pkt,
        input  rdy
    );

    modport slv (
        input  vld,
        input  pkt,
        output rdy
    );
endinterface

// File: rtl/ifu_fq.sv
// ifu_fq: queued fetch unit with in-flight PC FIFO, instruction buffer and redirect drop.
// Optional IFU_PERF_EN adds saturating fetch/drop/starve counters.
`ifndef RV_PC_SIZE
`define RV_PC_SIZE 32
`endif
`ifndef RV_IR_SIZE
`define RV_IR_SIZE 32
`endif

module ifu_fq #(
    parameter int              OST_DEPTH  = 2,
    parameter int              IBUF_DEPTH = 4,
    parameter int              PC_W       = `RV_PC_SIZE,
    parameter int              IR_W       = `RV_IR_SIZE,
    parameter logic [PC_W-1:0] RST_PC     = {PC_W{1'b0}}
) (
    input  logic        clk,
    input  logic        rst_n,
    ifu_fq_if.mst       fch_req_mst,
    ifu_fq_if.slv       fch_rsp_slv,
    ifu_fq_if.mst       ex_req_mst,
    ifu_fq_if.slv       rdr_req_slv
`ifdef IFU_PERF_EN
    ,
    output logic [31:0] perf_fch_cnt,
    output logic [31:0] perf_drop_cnt,
    output logic [31:0] perf_starve_cnt
`endif
);

    localparam int OW  = $clog2(OST_DEPTH + 1);
    localparam int BW  = $clog2(IBUF_DEPTH + 1);
    localparam int SW  = $clog2(OST_DEPTH + IBUF_DEPTH + 1);
    localparam int OPW = (OST_DEPTH > 1) ? $clog2(OST_DEPTH) : 1;
    localparam int IPW = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;

    typedef struct packed {
        logic [IR_W-1:0] raw;
    } ir_t;

    typedef struct packed {
        ir_t             ir;
        logic [PC_W-1:0] pc;
    } ex_pkt_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t          state;
    logic [PC_W-1:0] pc;
    logic [OW-1:0]   ost;
    logic [OW-1:0]   drop;
    logic [OW-1:0]   ost_eff;
    logic [OW-1:0]   drop_nxt;
    logic [SW-1:0]   occ;

    logic [PC_W-1:0] ofq [OST_DEPTH];
    logic [OPW-1:0]  ofq_wp;
    logic [OPW-1:0]  ofq_rp;

    ex_pkt_t         ibuf [IBUF_DEPTH];
    logic [IPW-1:0]  ib_wp;
    logic [IPW-1:0]  ib_rp;
    logic [BW-1:0]   ib_cnt;

    logic            rdr;
    logic            req_hsk;
    logic            rsp_hsk;
    logic            ex_hsk;
    logic            ib_push;

    function automatic logic [OPW-1:0] ofq_inc(input logic [OPW-1:0] p);
        return (p == OPW'(OST_DEPTH - 1)) ? '0 : p + OPW'(1);
    endfunction

    function automatic logic [IPW-1:0] ib_inc(input logic [IPW-1:0] p);
        return (p == IPW'(IBUF_DEPTH - 1)) ? '0 : p + IPW'(1);
    endfunction

    assign rdr     = rdr_req_slv.vld;
    assign req_hsk = fch_req_mst.vld & fch_req_mst.rdy;
    assign rsp_hsk = fch_rsp_slv.vld & fch_rsp_slv.rdy;
    assign ex_hsk  = ex_req_mst.vld & ex_req_mst.rdy;
    assign ib_push = rsp_hsk & (drop == '0) & ~rdr;

    // Requests are suppressed during a redirect, so req_hsk is 0 then.
    assign ost_eff = ost + OW'(req_hsk) - OW'(rsp_hsk);

    // Slots already promised to in-flight live responses count as used.
    assign occ = SW'(ost) + SW'(ib_cnt) - SW'(drop);

    always_comb begin
        drop_nxt = drop;
        if (rdr) begin
            drop_nxt = ost_eff;
        end else if (rsp_hsk && drop != '0) begin
            drop_nxt = drop - OW'(1);
        end
    end

    assign fch_req_mst.vld = (state != IDLE) & ~rdr
                           & (ost < OW'(OST_DEPTH))
                           & (occ < SW'(IBUF_DEPTH));
    assign fch_req_mst.pkt = pc;
    assign fch_rsp_slv.rdy = 1'b1;
    assign rdr_req_slv.rdy = 1'b1;
    assign ex_req_mst.vld  = (ib_cnt != '0) & ~rdr;
    assign ex_req_mst.pkt  = ibuf[ib_rp];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= (drop_nxt != '0) ? DRAIN : RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc   <= RST_PC;
            ost  <= '0;
            drop <= '0;
        end else begin
            ost  <= ost_eff;
            drop <= drop_nxt;
            if (rdr) begin
                pc <= rdr_req_slv.pkt;
            end else if (req_hsk) begin
                pc <= pc + PC_W'(4);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ofq_wp <= '0;
            ofq_rp <= '0;
            for (int i = 0; i < OST_DEPTH; i++) begin
                ofq[i] <= '0;
            end
        end else begin
            if (req_hsk) begin
                ofq[ofq_wp] <= pc;
                ofq_wp      <= ofq_inc(ofq_wp);
            end
            if (rsp_hsk) begin
                ofq_rp <= ofq_inc(ofq_rp);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ib_wp  <= '0;
            ib_rp  <= '0;
            ib_cnt <= '0;
            for (int i = 0; i < IBUF_DEPTH; i++) begin
                ibuf[i] <= '0;
            end
        end else if (rdr) begin
            ib_wp  <= '0;
            ib_rp  <= '0;
            ib_cnt <= '0;
        end else begin
            if (ib_push) begin
                ibuf[ib_wp] <= {fch_rsp_slv.pkt, ofq[ofq_rp]};
                ib_wp       <= ib_inc(ib_wp);
            end
            if (ex_hsk) begin
                ib_rp <= ib_inc(ib_rp);
            end
            ib_cnt <= ib_cnt + BW'(ib_push) - BW'(ex_hsk);
        end
    end

`ifdef IFU_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fch_cnt    <= '0;
            perf_drop_cnt   <= '0;
            perf_starve_cnt <= '0;
        end else begin
            if (req_hsk && perf_fch_cnt != '1) begin
                perf_fch_cnt <= perf_fch_cnt + 32'd1;
            end
            if (rsp_hsk && drop != '0 && perf_drop_cnt != '1) begin
                perf_drop_cnt <= perf_drop_cnt + 32'd1;
            end
            if (state == RUN && ib_cnt == '0 && perf_starve_cnt != '1) begin
                perf_starve_cnt <= perf_starve_cnt + 32'd1;
            end
        end
    end
`endif

    a_rsp_ost: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(fch_rsp_slv.vld && ost == '0)
    );

endmodule

// File: tb/tb_ifu_fq.sv
// tb_ifu_fq: random and directed stimulus against a queue-based model
// of fetch order, buffering and redirect discard.
module tb_ifu_fq;

    localparam int PC_W = 32;
    localparam int IR_W = 32;

    typedef struct {
        logic [31:0] pc;
        bit          stale;
    } mreq_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ifu_fq_if #(.W(PC_W))        fch_req ();
    ifu_fq_if #(.W(IR_W))        fch_rsp ();
    ifu_fq_if #(.W(IR_W + PC_W)) ex_req ();
    ifu_fq_if #(.W(PC_W))        rdr_req ();

`ifdef IFU_PERF_EN
    logic [31:0] perf_fch_cnt;
    logic [31:0] perf_drop_cnt;
    logic [31:0] perf_starve_cnt;
`endif

    ifu_fq #(
        .OST_DEPTH (2),
        .IBUF_DEPTH(4),
        .PC_W      (PC_W),
        .IR_W      (IR_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fch_req_mst(fch_req),
        .fch_rsp_slv(fch_rsp),
        .ex_req_mst (ex_req),
        .rdr_req_slv(rdr_req)
`ifdef IFU_PERF_EN
        ,
        .perf_fch_cnt   (perf_fch_cnt),
        .perf_drop_cnt  (perf_drop_cnt),
        .perf_starve_cnt(perf_starve_cnt)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    mreq_t       mq [$];
    logic [31:0] bq [$];
    logic [31:0] fpc;
    bit          run;
    int          n_fetch;
    int          n_drop;
    int          n_starve;
    logic [31:0] fetch_log [$];
    logic [31:0] ex_log [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ir_of(input logic [31:0] pc);
        return (pc * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    function automatic int n_stale();
        int n = 0;
        foreach (mq[i]) if (mq[i].stale) n++;
        return n;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        fch_req.rdy = 1'b0;
        fch_rsp.vld = 1'b0;
        fch_rsp.pkt = '0;
        ex_req.rdy  = 1'b0;
        rdr_req.vld = 1'b0;
        rdr_req.pkt = '0;
        #1;
        chk("rst_fch_vld", 64'(fch_req.vld), 64'(0));
        chk("rst_fch_pc", 64'(fch_req.pkt), 64'(0));
        chk("rst_ex_vld", 64'(ex_req.vld), 64'(0));
        chk("rst_ex_pkt", 64'(ex_req.pkt), 64'(0));
        chk("rst_rsp_rdy", 64'(fch_rsp.rdy), 64'(1));
        chk("rst_rdr_rdy", 64'(rdr_req.rdy), 64'(1));
`ifdef IFU_PERF_EN
        chk("rst_perf_fch", 64'(perf_fch_cnt), 64'(0));
        chk("rst_perf_drop", 64'(perf_drop_cnt), 64'(0));
        chk("rst_perf_starve", 64'(perf_starve_cnt), 64'(0));
`endif
        mq.delete();
        bq.delete();
        fetch_log.delete();
        ex_log.delete();
        fpc      = 32'h0;
        run      = 1'b0;
        n_fetch  = 0;
        n_drop   = 0;
        n_starve = 0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic step(input bit rv, input logic [31:0] rpc, input bit rsp_en,
                        input bit exr, input bit fr);
        bit rsp_v, e_fv, e_xv, req_h, ex_h;
        int stale;
        mreq_t e;
        @(negedge clk);
        rsp_v       = rsp_en && mq.size() > 0;
        rdr_req.vld = rv;
        rdr_req.pkt = rpc;
        fch_rsp.vld = rsp_v;
        fch_rsp.pkt = rsp_v ? ir_of(mq[0].pc) : 32'h0;
        ex_req.rdy  = exr;
        fch_req.rdy = fr;
        #1;
        stale = n_stale();
        e_fv  = run && !rv && mq.size() < 2 && (mq.size() + bq.size() - stale) < 4;
        e_xv  = bq.size() > 0 && !rv;
        chk("fch_vld", 64'(fch_req.vld), 64'(e_fv));
        if (e_fv) chk("fch_pc", 64'(fch_req.pkt), 64'(fpc));
        chk("ex_vld", 64'(ex_req.vld), 64'(e_xv));
        if (e_xv) chk("ex_pkt", 64'(ex_req.pkt), {ir_of(bq[0]), bq[0]});
`ifdef IFU_PERF_EN
        chk("perf_fch", 64'(perf_fch_cnt), 64'(n_fetch));
        chk("perf_drop", 64'(perf_drop_cnt), 64'(n_drop));
        chk("perf_starve", 64'(perf_starve_cnt), 64'(n_starve));
`endif
        req_h = e_fv && fr;
        ex_h  = e_xv && exr;
        @(posedge clk);
        if (run && stale == 0 && bq.size() == 0) n_starve++;
        if (rsp_v) begin
            e = mq.pop_front();
            if (e.stale) n_drop++;
            else if (!rv) bq.push_back(e.pc);
        end
        if (ex_h) ex_log.push_back(bq.pop_front());
        if (req_h) begin
            mq.push_back('{pc: fpc, stale: 1'b0});
            fetch_log.push_back(fpc);
            n_fetch++;
            fpc = fpc + 32'd4;
        end
        if (rv) begin
            fpc = rpc;
            bq.delete();
            foreach (mq[i]) mq[i].stale = 1'b1;
        end
        run = 1'b1;
    endtask

    initial begin
        int k;
        int d0;
        int e0;
        fch_req.rdy = 1'b0;
        fch_rsp.vld = 1'b0;
        fch_rsp.pkt = '0;
        ex_req.rdy  = 1'b0;
        rdr_req.vld = 1'b0;
        rdr_req.pkt = '0;

        // straight-line fetch, 1-cycle memory, ex always ready
        do_reset();
        repeat (30) step(0, 0, 1, 1, 1);
        chk("seq_fetch2", 64'(fetch_log[2]), 64'(32'h8));
        chk("seq_ex_cnt", 64'(ex_log.size() >= 20), 64'(1));

        // ex stalled: buffer fills to exactly 4, then drains in order
        do_reset();
        repeat (20) step(0, 0, 1, 0, 1);
        chk("fill_fetches", 64'(n_fetch), 64'(4));
        repeat (8) step(0, 0, 1, 1, 1);
        chk("drain_0", 64'(ex_log.size() > 3 ? ex_log[0] : 32'hDEAD), 64'(32'h0));
        chk("drain_3", 64'(ex_log.size() > 3 ? ex_log[3] : 32'hDEAD), 64'(32'hC));

        // redirect with two requests in flight
        do_reset();
        k = 0;
        while (mq.size() < 2 && k < 20) begin
            step(0, 0, 0, 1, 1);
            k++;
        end
        chk("ost_full", 64'(mq.size()), 64'(2));
        ex_log.delete();
        d0 = n_drop;
        step(1, 32'h100, 0, 1, 1);
        repeat (2) step(0, 0, 1, 1, 0);
        chk("rdr_drops", 64'(n_drop - d0), 64'(2));
        repeat (8) step(0, 0, 1, 1, 1);
        chk("rdr_first", 64'(ex_log.size() > 0 ? ex_log[0] : 32'hDEAD), 64'(32'h100));

        // redirect coinciding with a response and an ex attempt
        do_reset();
        repeat (3) step(0, 0, 0, 0, 1);
        step(0, 0, 1, 0, 0);
        e0 = ex_log.size();
        fetch_log.delete();
        step(1, 32'h200, 1, 1, 1);
        step(0, 0, 0, 1, 1);
        chk("same_cyc_ex", 64'(ex_log.size()), 64'(e0));
        chk("same_cyc_fch", 64'(fetch_log.size() > 0 ? fetch_log[0] : 32'hDEAD), 64'(32'h200));

        // PC wrap
        fetch_log.delete();
        step(1, 32'hFFFF_FFFC, 1, 1, 1);
        repeat (10) step(0, 0, 1, 1, 1);
        chk("wrap_0", 64'(fetch_log.size() > 1 ? fetch_log[0] : 32'hDEAD), 64'(32'hFFFF_FFFC));
        chk("wrap_1", 64'(fetch_log.size() > 1 ? fetch_log[1] : 32'hDEAD), 64'(32'h0));

        // random traffic, then reset in the middle of it
        for (int r = 0; r < 3; r++) begin
            do_reset();
            repeat (1500) begin
                step(($urandom % 16) == 0,
                     ($urandom % 6 == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC),
                     ($urandom % 10) < 6,
                     ($urandom % 10) < 7,
                     ($urandom % 4) != 0);
            end
        end
        do_reset();
        repeat (4) step(0, 0, 1, 1, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
